// File: rtl/entity_tick_scheduler.sv
// Frame-rate scheduler for the game loop. It handles PAUSED/RUN/HALTED control, per-entity update
// tick strobes and a locking round-robin arbiter for the shared grid/collision port.
module entity_tick_scheduler #(
    parameter int PLAYER_PERIOD = 4,
    parameter int DRAGON_PERIOD = 8,
    parameter int SHEEP_PERIOD  = 16
) (
    input  logic       frame_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       game_over,
    input  logic [2:0] req,
    output logic [2:0] tick,
    output logic [2:0] grant,
    output logic [1:0] sched_state,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        PAUSED = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [2:0][4:0] CNT_MAX = {5'(SHEEP_PERIOD - 1),
                                           5'(DRAGON_PERIOD - 1),
                                           5'(PLAYER_PERIOD - 1)};

    state_t          state;
    state_t          state_nxt;
    logic            start_prev;
    logic            start_press;
    logic            run_edge;
    logic [2:0][4:0] cnt;
    logic [2:0][4:0] cnt_nxt;
    logic [2:0]      wrap;
    logic [1:0]      last_granted;
    logic [1:0]      last_nxt;
    logic [2:0]      grant_nxt;
    logic            found;
    int              arb_idx;

    assign start_press = start & ~start_prev;
    assign sched_state = state;

    // The edge that leaves RUN does not count as a RUN frame, so a pause resumes on the exact phase.
    assign run_edge = (state == RUN) && (state_nxt == RUN);

    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            state <= PAUSED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PAUSED: begin
                if (game_over)        state_nxt = HALTED;
                else if (start_press) state_nxt = RUN;
            end
            RUN: begin
                if (game_over)        state_nxt = HALTED;
                else if (start_press) state_nxt = PAUSED;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = PAUSED;
        endcase
    end

    always_comb begin
        wrap    = '0;
        cnt_nxt = cnt;
        for (int i = 0; i < 3; i++) begin
            wrap[i]    = (cnt[i] == CNT_MAX[i]);
            cnt_nxt[i] = wrap[i] ? 5'd0 : cnt[i] + 5'd1;
        end
    end

    // The current owner keeps the port while it still requests. Otherwise the search starts one
    // past the last owner.
    always_comb begin
        grant_nxt = '0;
        last_nxt  = last_granted;
        found     = 1'b0;
        arb_idx   = 0;
        if ((grant & req) != 3'b000) begin
            grant_nxt = grant;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                arb_idx = (int'(last_granted) + k) % 3;
                if (!found && req[arb_idx]) begin
                    found              = 1'b1;
                    grant_nxt[arb_idx] = 1'b1;
                    last_nxt           = 2'(arb_idx);
                end
            end
        end
    end

    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            start_prev   <= 1'b0;
            cnt          <= '0;
            tick         <= '0;
            grant        <= '0;
            last_granted <= 2'd2;
            frame_count  <= '0;
        end else begin
            start_prev <= start;
            if (run_edge) begin
                cnt          <= cnt_nxt;
                tick         <= wrap;
                grant        <= grant_nxt;
                last_granted <= last_nxt;
                frame_count  <= frame_count + 8'd1;
            end else begin
                tick  <= '0;
                grant <= '0;
            end
        end
    end

endmodule
